twd_stage_ctrl: RTL and testbench
=================================

# twd_stage_ctrl

Frame sequencer for one radix-2 FFT stage built around a twiddle multiplier. It counts the 16-lane vectors of a frame and drives the twiddle index that selects the factor (1 or -j) for each vector. It also delays valid, start-of-frame and end-of-frame markers to match the stage pipeline. It sits between the butterfly output of stage N and the twiddle multiplier, replacing the free-running counter with a frame-aware, stall-tolerant one.

## Interface
- CLK_CNT, 4: counter width; frame = 2**CLK_CNT vectors; legal ≥1.
- PIPE_LAT, 3: stage pipeline depth in cycles; legal ≥1.
- clk  in  1  rising-edge clock.
- rstn  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous clear; same effect as reset, one cycle.
- in_valid  in  1  a 16-lane vector is present this cycle.
- twd_idx  out  CLK_CNT  index of the current input vector within the frame; stage uses twd_idx[0].
- in_sof  out  1  current input vector is index 0.
- in_eof  out  1  current input vector is index 2**CLK_CNT-1.
- out_valid  out  1  in_valid delayed PIPE_LAT cycles.
- out_sof / out_eof  out  1  in_sof&in_valid / in_eof&in_valid delayed PIPE_LAT cycles.
- frame_done  out  1  one-cycle pulse, equal to out_eof.
- busy  out  1  state≠IDLE or any delay-line bit set.
- err  out  1  one-cycle pulse on frame abort; build without the stall feature only.

## Operation
- States: IDLE, RUN, STALL.
- IDLE:
  - cnt=0.
  - in_valid → accept index 0, cnt←1, go RUN.
  - If CLK_CNT would make a frame one vector long, it does not; CLK_CNT≥1 guarantees ≥2 vectors.
- RUN:
  - in_valid → cnt←cnt+1.
  - in_valid with cnt=max → cnt←0, go IDLE (frame complete).
  - in_valid low → see Configuration.
- STALL (stall build only):
  - cnt held.
  - in_valid → resume as RUN, incrementing from the held cnt.
- twd_idx = cnt register, combinational to output. It is valid in the same cycle as in_valid.
- in_sof = (cnt==0); in_eof = (cnt==max). Both are decoded from cnt, independent of in_valid.
- Back-to-back frames: in_valid at max is followed by in_valid at 0 with no gap. Frame boundaries pass through the delay line independently of the state.
- Delay line: PIPE_LAT-deep shift of {valid, sof, eof}. It shifts every cycle, including during stalls, because the stage pipeline is not stalled.
- clr: cnt=0, state=IDLE, delay line zeroed on the next edge. in_valid in the clr cycle is dropped.
- cnt wraps modulo 2**CLK_CNT. No saturation.

## Timing
- Reset values: cnt=0, state=IDLE, delay line 0. Therefore twd_idx=0, in_sof=1, in_eof=0, out_*=0, frame_done=0, busy=0, err=0.
- Asynchronous reset mid-frame: all of the above take effect immediately. The partial frame is discarded with no err pulse.
- Latency from in_valid to out_valid: exactly PIPE_LAT cycles.
- Latency from the last vector of a frame to frame_done: PIPE_LAT cycles.
- Throughput: one vector per cycle; no backpressure.
- busy falls PIPE_LAT cycles after the last accepted vector, when no new frame has started.
- err: registered, asserted the cycle after the gap.

## Configuration
- TWD_STAGE_CTRL_STALL_EN defined:
  - in_valid low in RUN → STALL, cnt held.
  - The frame completes when the remaining vectors arrive.
  - err port tied 0.
- TWD_STAGE_CTRL_STALL_EN undefined:
  - in_valid low in RUN → frame abort: cnt←0, state←IDLE, err pulses 1 cycle.
  - Delay-line entries already issued still drain.
  - No STALL state is synthesised.

## Test plan
- Reset then 16 consecutive in_valid (CLK_CNT=4, PIPE_LAT=3):
  - twd_idx 0..15, twd_idx[0] alternating 0,1.
  - in_sof at vector 0, in_eof at vector 15.
  - out_valid high for cycles 3..18; frame_done at cycle 18 (vector 15 in at cycle 15).
  - busy low at cycle 19.
- Two frames back-to-back (32 vectors):
  - twd_idx wraps 15→0 with no gap.
  - Two frame_done pulses 16 cycles apart; busy stays high throughout.
- Stall build: gap of 4 cycles after vector 6.
  - twd_idx holds at 7 during the gap, state STALL.
  - Resumes at 7; frame_done 3 cycles after vector 15.
  - out_valid shows the 4-cycle hole.
- No-stall build: same gap.
  - err pulses 1 cycle after the gap starts; cnt returns to 0.
  - The next in_valid is treated as sof; the 7 issued vectors still emerge on out_valid.
- clr asserted at vector 9, then separately rstn asserted at vector 9:
  - twd_idx=0, out_valid=0 the next cycle with no frame_done.
  - For rstn, outputs clear asynchronously before the next edge.
- PIPE_LAT=1, CLK_CNT=1:
  - vectors alternate twd_idx 0,1.
  - out_valid one cycle after in_valid; frame_done every 2nd vector.

Source files
------------

// File: rtl/twd_stage_ctrl.sv
// Frame-aware twiddle-index sequencer for one radix-2 FFT stage, with a matching delay line for the valid/sof/eof markers.
// Build option: define TWD_STAGE_CTRL_STALL_EN to hold the frame across in_valid gaps instead of aborting it.
module twd_stage_ctrl #(
  parameter int unsigned CLK_CNT  = 4,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               in_valid,
  output logic [CLK_CNT-1:0] twd_idx,
  output logic               in_sof,
  output logic               in_eof,
  output logic               out_valid,
  output logic               out_sof,
  output logic               out_eof,
  output logic               frame_done,
  output logic               busy,
  output logic               err
);

  localparam logic [CLK_CNT-1:0] CNT_MAX = '1;

`ifdef TWD_STAGE_CTRL_STALL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [CLK_CNT-1:0] cnt_q, cnt_d;
  logic               err_d;
  logic [2:0]         dly_q [PIPE_LAT];
  logic               dly_any;

`ifndef TWD_STAGE_CTRL_STALL_EN
  logic err_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifndef TWD_STAGE_CTRL_STALL_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifndef TWD_STAGE_CTRL_STALL_EN
      err_q   <= err_d;
`endif
    end
  end

  // cnt is always 0 in IDLE, so IDLE acceptance is the same +1 step as RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = RUN;
          end
        end
`ifdef TWD_STAGE_CTRL_STALL_EN
        RUN, STALL: begin
          if (in_valid) begin
            if (cnt_q == CNT_MAX) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = RUN;
            end
          end else begin
            state_d = STALL;
          end
        end
`else
        RUN: begin
          if (in_valid) begin
            if (cnt_q == CNT_MAX) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The stage pipeline never stalls, so the marker line shifts every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) dly_q[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {in_valid, in_valid & in_sof, in_valid & in_eof};
      for (int unsigned i = 1; i < PIPE_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  always_comb begin
    dly_any = 1'b0;
    for (int unsigned i = 0; i < PIPE_LAT; i++) dly_any = dly_any | (|dly_q[i]);
  end

  always_comb begin
    twd_idx    = cnt_q;
    in_sof     = (cnt_q == '0);
    in_eof     = (cnt_q == CNT_MAX);
    out_valid  = dly_q[PIPE_LAT-1][2];
    out_sof    = dly_q[PIPE_LAT-1][1];
    out_eof    = dly_q[PIPE_LAT-1][0];
    frame_done = dly_q[PIPE_LAT-1][0];
    busy       = (state_q != IDLE) | dly_any;
`ifdef TWD_STAGE_CTRL_STALL_EN
    err        = 1'b0;
`else
    err        = err_q;
`endif
  end

endmodule

// File: tb/tb_twd_stage_ctrl.sv
// Directed bench for twd_stage_ctrl: CLK_CNT=4/PIPE_LAT=3 instance against a scoreboard model, plus a CLK_CNT=1/PIPE_LAT=1 instance.
module tb_twd_stage_ctrl;

  localparam int MAX = 15;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clr;
  logic       in_valid;
  logic [3:0] twd_idx;
  logic       in_sof, in_eof, out_valid, out_sof, out_eof, frame_done, busy, err;

  logic       iv1;
  logic [0:0] twd_idx1;
  logic       in_sof1, in_eof1, out_valid1, out_sof1, out_eof1, frame_done1, busy1, err1;

  int checks = 0;
  int errors = 0;

  // model state
  int         m_cnt;
  int         m_state;  // 0 idle, 1 run, 2 stall
  logic       m_err;
  logic [2:0] sb_q[$];
  int         t;
  int         fd_log[$];
  int         err_log[$];
  int         idx_hist[$];
  logic       ov_hist[$];

  twd_stage_ctrl #(.CLK_CNT(4), .PIPE_LAT(3)) u_dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid),
    .twd_idx(twd_idx), .in_sof(in_sof), .in_eof(in_eof),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .frame_done(frame_done), .busy(busy), .err(err)
  );

  twd_stage_ctrl #(.CLK_CNT(1), .PIPE_LAT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .clr(1'b0), .in_valid(iv1),
    .twd_idx(twd_idx1), .in_sof(in_sof1), .in_eof(in_eof1),
    .out_valid(out_valid1), .out_sof(out_sof1), .out_eof(out_eof1),
    .frame_done(frame_done1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic m_busy();
    logic b;
    b = (m_state != 0);
    foreach (sb_q[i]) b = b | (|sb_q[i]);
    return b;
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_state = 0;
    m_err   = 1'b0;
    sb_q    = {};
    repeat (LAT) sb_q.push_back(3'b000);
  endtask

  task automatic new_section();
    t = 0;
    fd_log = {};
    err_log = {};
    idx_hist = {};
    ov_hist = {};
  endtask

  // Called at posedge+1; checks at negedge, then advances the model across the edge.
  task automatic step(input logic v, input logic c);
    logic [2:0] e;
    in_valid = v;
    clr      = c;
    #4;
    e = sb_q[0];
    chk("twd_idx",    32'(twd_idx),    32'(m_cnt));
    chk("in_sof",     32'(in_sof),     32'(m_cnt == 0));
    chk("in_eof",     32'(in_eof),     32'(m_cnt == MAX));
    chk("out_valid",  32'(out_valid),  32'(e[2]));
    chk("out_sof",    32'(out_sof),    32'(e[1]));
    chk("out_eof",    32'(out_eof),    32'(e[0]));
    chk("frame_done", 32'(frame_done), 32'(e[0]));
    chk("busy",       32'(busy),       32'(m_busy()));
    chk("err",        32'(err),        32'(m_err));
    if (frame_done) fd_log.push_back(t);
    if (err) err_log.push_back(t);
    idx_hist.push_back(int'(twd_idx));
    ov_hist.push_back(out_valid);
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      void'(sb_q.pop_front());
      sb_q.push_back({v, v && (m_cnt == 0), v && (m_cnt == MAX)});
      m_err = 1'b0;
      if (v) begin
        if (m_state != 0 && m_cnt == MAX) begin
          m_cnt = 0;
          m_state = 0;
        end else begin
          m_cnt = m_cnt + 1;
          m_state = 1;
        end
      end else if (m_state != 0) begin
`ifdef TWD_STAGE_CTRL_STALL_EN
        m_state = 2;
`else
        m_cnt = 0;
        m_state = 0;
        m_err = 1'b1;
`endif
      end
    end
    t++;
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    iv1 = 1'b0;
    model_reset();
    #2;
    chk("rst_twd_idx",    32'(twd_idx),    32'd0);
    chk("rst_in_sof",     32'(in_sof),     32'd1);
    chk("rst_in_eof",     32'(in_eof),     32'd0);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_err",        32'(err),        32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // single frame
    new_section();
    repeat (16) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    chk("f1_fd_count", 32'(fd_log.size()), 32'd1);
    if (fd_log.size() > 0) chk("f1_fd_cycle", 32'(fd_log[0]), 32'd18);
    for (int k = 0; k < 16; k++) chk("f1_idx", 32'(idx_hist[k]), 32'(k));
    chk("f1_ov_first", 32'(ov_hist[3]), 32'd1);
    chk("f1_ov_before", 32'(ov_hist[2]), 32'd0);
    chk("f1_ov_after", 32'(ov_hist[19]), 32'd0);

    // back-to-back frames
    new_section();
    repeat (32) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    chk("b2b_fd_count", 32'(fd_log.size()), 32'd2);
    if (fd_log.size() == 2) begin
      chk("b2b_fd0", 32'(fd_log[0]), 32'd18);
      chk("b2b_fd1", 32'(fd_log[1]), 32'd34);
    end
    chk("b2b_wrap_lo", 32'(idx_hist[16]), 32'd0);
    chk("b2b_wrap_hi", 32'(idx_hist[15]), 32'd15);

    // gap of 4 cycles after vector 6
    new_section();
    repeat (7) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
`ifdef TWD_STAGE_CTRL_STALL_EN
    repeat (9) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    chk("gap_idx_held", 32'(idx_hist[9]), 32'd7);
    chk("gap_idx_resume", 32'(idx_hist[11]), 32'd7);
    chk("gap_err_count", 32'(err_log.size()), 32'd0);
    chk("gap_fd_count", 32'(fd_log.size()), 32'd1);
    if (fd_log.size() > 0) chk("gap_fd_cycle", 32'(fd_log[0]), 32'd22);
`else
    repeat (16) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    chk("gap_idx_abort", 32'(idx_hist[8]), 32'd0);
    chk("gap_err_count", 32'(err_log.size()), 32'd1);
    if (err_log.size() > 0) chk("gap_err_cycle", 32'(err_log[0]), 32'd8);
    chk("gap_new_sof", 32'(idx_hist[11]), 32'd0);
    chk("gap_fd_count", 32'(fd_log.size()), 32'd1);
    if (fd_log.size() > 0) chk("gap_fd_cycle", 32'(fd_log[0]), 32'd29);
`endif
    chk("gap_ov_last_issued", 32'(ov_hist[9]), 32'd1);
    chk("gap_ov_hole", 32'(ov_hist[12]), 32'd0);

    // synchronous clear at vector 9
    new_section();
    repeat (9) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0);
    chk("clr_idx", 32'(idx_hist[10]), 32'd0);
    chk("clr_ov", 32'(ov_hist[10]), 32'd0);
    chk("clr_fd_count", 32'(fd_log.size()), 32'd0);

    // asynchronous reset at vector 9
    new_section();
    repeat (9) step(1'b1, 1'b0);
    in_valid = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_twd_idx",   32'(twd_idx),    32'd0);
    chk("arst_in_sof",    32'(in_sof),     32'd1);
    chk("arst_out_valid", 32'(out_valid),  32'd0);
    chk("arst_fd",        32'(frame_done), 32'd0);
    chk("arst_busy",      32'(busy),       32'd0);
    chk("arst_err",       32'(err),        32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    repeat (5) step(1'b0, 1'b0);
    chk("arst_fd_count", 32'(fd_log.size()), 32'd0);
    chk("arst_err_count", 32'(err_log.size()), 32'd0);

    // CLK_CNT=1, PIPE_LAT=1 instance
    for (int k = 0; k < 10; k++) begin
      iv1 = (k < 8);
      #4;
      chk("p1_out_valid", 32'(out_valid1), 32'(k >= 1 && k <= 8));
      chk("p1_frame_done", 32'(frame_done1), 32'(k >= 2 && k <= 8 && (k % 2) == 0));
      if (k < 8) begin
        chk("p1_twd_idx", 32'(twd_idx1), 32'(k % 2));
        chk("p1_in_sof", 32'(in_sof1), 32'((k % 2) == 0));
      end
      @(posedge clk);
      #1;
    end
    chk("p1_busy_idle", 32'(busy1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
